// File: rtl/ram64x1_word_arbiter_if.sv
// Bus bundle for two word-level requesters and the 64x1 RAM primitive behind the arbiter.
interface ram64x1_word_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             REQ0;
  logic             WR0;
  logic [5:0]       ADDR0;
  logic [WIDTH-1:0] WDATA0;
  logic             ACK0;
  logic [WIDTH-1:0] RDATA0;

  logic             REQ1;
  logic             WR1;
  logic [5:0]       ADDR1;
  logic [WIDTH-1:0] WDATA1;
  logic             ACK1;
  logic [WIDTH-1:0] RDATA1;

  logic [5:0]       RAM_A;
  logic             RAM_D;
  logic             RAM_WE;
  logic             RAM_O;

  logic             BUSY;

  // Arbiter side
  modport slave (
    input  REQ0, WR0, ADDR0, WDATA0,
    input  REQ1, WR1, ADDR1, WDATA1,
    input  RAM_O,
    output ACK0, RDATA0, ACK1, RDATA1,
    output RAM_A, RAM_D, RAM_WE, BUSY
  );

  // Client / environment side
  modport master (
    output REQ0, WR0, ADDR0, WDATA0,
    output REQ1, WR1, ADDR1, WDATA1,
    output RAM_O,
    input  ACK0, RDATA0, ACK1, RDATA1,
    input  RAM_A, RAM_D, RAM_WE, BUSY
  );
endinterface

// File: rtl/ram64x1_word_arbiter.sv
// Round-robin arbiter that shares one 64x1 distributed RAM between two requesters,
// turning each WIDTH-bit word access into WIDTH single-bit RAM cycles.
// The RAM writes on the falling edge of CLK, so every RAM-facing output is registered
// on the rising edge and stays stable across that falling edge.
module ram64x1_word_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  ram64x1_word_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  localparam logic [5:0] LAST_BIT = 6'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [5:0]       bit_q,    bit_d;
  logic             owner_q,  owner_d;
  logic             last_q,   last_d;
  logic             wr_q,     wr_d;
  logic [5:0]       base_q,   base_d;
  logic [WIDTH-1:0] wdata_q,  wdata_d;
  logic [WIDTH-1:0] rbuf_q,   rbuf_d;
  logic             ack0_q,   ack0_d;
  logic             ack1_q,   ack1_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic [5:0]       ram_a_q,  ram_a_d;
  logic             ram_d_q,  ram_d_d;
  logic             ram_we_q, ram_we_d;
  logic             busy_q,   busy_d;

  logic             grant;
  logic [5:0]       next_bit;
  logic [WIDTH-1:0] bit_mask;

  // Next-state logic: grant in IDLE, walk the bits in XFER, report completion in DONE
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wr_d     = wr_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ram_a_d  = ram_a_q;
    ram_d_d  = ram_d_q;
    ram_we_d = ram_we_q;
    busy_d   = busy_q;
    grant    = 1'b0;
    next_bit = bit_q + 6'd1;
    bit_mask = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          // On a tie the requester that was not served last wins
          grant    = (bus.REQ0 && bus.REQ1) ? ~last_q : bus.REQ1;
          owner_d  = grant;
          last_d   = grant;
          wr_d     = grant ? bus.WR1    : bus.WR0;
          base_d   = grant ? bus.ADDR1  : bus.ADDR0;
          wdata_d  = grant ? bus.WDATA1 : bus.WDATA0;
          bit_d    = '0;
          ram_a_d  = base_d;
          ram_we_d = wr_d;
          ram_d_d  = wdata_d[0];
          busy_d   = 1'b1;
          state_d  = XFER;
        end
      end

      XFER: begin
        // The RAM output for the current bit is valid by this rising edge
        bit_mask = WIDTH'(1) << bit_q;
        rbuf_d   = bus.RAM_O ? (rbuf_q | bit_mask) : (rbuf_q & ~bit_mask);
        if (bit_q == LAST_BIT) begin
          state_d  = DONE;
          ram_we_d = 1'b0;
          busy_d   = 1'b0;
          if (owner_q) begin
            ack1_d = 1'b1;
            if (!wr_q) rdata1_d = rbuf_d;
          end else begin
            ack0_d = 1'b1;
            if (!wr_q) rdata0_d = rbuf_d;
          end
        end else begin
          // Six-bit address arithmetic wraps 63 -> 0 on its own
          bit_d   = next_bit;
          ram_a_d = base_q + next_bit;
          ram_d_d = |(wdata_q & (WIDTH'(1) << next_bit));
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight without an ACK
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ram_a_q  <= '0;
      ram_d_q  <= 1'b0;
      ram_we_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ram_a_q  <= ram_a_d;
      ram_d_q  <= ram_d_d;
      ram_we_q <= ram_we_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ACK0   = ack0_q;
  assign bus.ACK1   = ack1_q;
  assign bus.RDATA0 = rdata0_q;
  assign bus.RDATA1 = rdata1_q;
  assign bus.RAM_A  = ram_a_q;
  assign bus.RAM_D  = ram_d_q;
  assign bus.RAM_WE = ram_we_q;
  assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_ram64x1_word_arbiter.sv
// Testbench for ram64x1_word_arbiter: a 64x1 RAM model, a transaction-level reference
// model, a per-cycle compare process and directed plus random requester traffic.
`timescale 1ns/1ps
module tb_ram64x1_word_arbiter;

  localparam int WIDTH = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  ram64x1_word_arbiter_if #(.WIDTH(WIDTH)) bus ();

  ram64x1_word_arbiter #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] init_bits;
  logic [63:0] ram_mem;
  bit          ram_ready = 1'b0;

  // 64x1 RAM primitive: asynchronous read, write on the falling clock edge
  assign bus.RAM_O = ram_mem[bus.RAM_A];

  always @(negedge CLK) begin
    if (!ram_ready) begin
      ram_mem   = init_bits;
      ram_ready = 1'b1;
    end
    if (bus.RAM_WE === 1'b1) ram_mem[bus.RAM_A] = bus.RAM_D;
  end

  // Reference model state
  logic [63:0]      ref_mem;
  bit               ref_ready = 1'b0;
  int               edge_n = 0;
  bit               started = 1'b0;
  bit               m_active = 1'b0;
  int               m_g = 0;
  bit               m_owner = 1'b0;
  bit               m_wr = 1'b0;
  logic [5:0]       m_base = '0;
  logic [WIDTH-1:0] m_wdata = '0;
  int               m_next_free = 0;
  bit               m_last = 1'b1;
  bit               exp_ack [2];
  logic [WIDTH-1:0] exp_rdata [2];
  bit               exp_busy, exp_we, exp_ad, exp_d;
  logic [5:0]       exp_a;

  int ack_who[$];
  int ack_edge[$];

  function automatic logic [WIDTH-1:0] ref_read(input logic [5:0] base);
    logic [WIDTH-1:0] w;
    for (int j = 0; j < WIDTH; j++) w[j] = ref_mem[(int'(base) + j) % 64];
    return w;
  endfunction

  task automatic ref_write(input logic [5:0] base, input logic [WIDTH-1:0] w, input int nbits);
    for (int j = 0; j < nbits; j++) ref_mem[(int'(base) + j) % 64] = w[j];
  endtask

  // Transaction-level reference: a granted word owns the RAM for WIDTH edges starting at
  // the grant edge, completes WIDTH edges later, and the next grant may happen two edges after that
  always @(posedge CLK) begin : model_p
    int j;
    if (!ref_ready) begin
      ref_mem   = init_bits;
      ref_ready = 1'b1;
    end
    edge_n++;
    if (RST) begin
      if (m_active && m_wr) ref_write(m_base, m_wdata, edge_n - m_g);
      m_active     = 1'b0;
      m_last       = 1'b1;
      m_next_free  = edge_n + 1;
      exp_ack[0]   = 1'b0;
      exp_ack[1]   = 1'b0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      exp_busy     = 1'b0;
      exp_we       = 1'b0;
      exp_ad       = 1'b1;
      exp_a        = '0;
      exp_d        = 1'b0;
      started      = 1'b1;
    end else begin
      exp_ack[0] = 1'b0;
      exp_ack[1] = 1'b0;
      if (m_active && edge_n == m_g + WIDTH) begin
        exp_ack[m_owner] = 1'b1;
        if (m_wr) ref_write(m_base, m_wdata, WIDTH);
        else      exp_rdata[m_owner] = ref_read(m_base);
        m_active = 1'b0;
      end
      if (!m_active && edge_n >= m_next_free && (bus.REQ0 || bus.REQ1)) begin
        if (bus.REQ0 && bus.REQ1) m_owner = !m_last;
        else                      m_owner = bus.REQ1;
        m_last      = m_owner;
        m_g         = edge_n;
        m_wr        = m_owner ? bus.WR1    : bus.WR0;
        m_base      = m_owner ? bus.ADDR1  : bus.ADDR0;
        m_wdata     = m_owner ? bus.WDATA1 : bus.WDATA0;
        m_next_free = edge_n + WIDTH + 2;
        m_active    = 1'b1;
      end
      if (m_active) begin
        j        = edge_n - m_g;
        exp_busy = 1'b1;
        exp_we   = m_wr;
        exp_a    = 6'((int'(m_base) + j) % 64);
        exp_d    = m_wdata[j];
        exp_ad   = 1'b1;
      end else begin
        exp_busy = 1'b0;
        exp_we   = 1'b0;
        exp_ad   = 1'b0;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compares every DUT output against the reference model one time unit after each rising edge
  task automatic compare_loop();
    forever begin
      @(posedge CLK);
      #1;
      if (started) begin
        check_output("ack0",   bus.ACK0,   exp_ack[0]);
        check_output("ack1",   bus.ACK1,   exp_ack[1]);
        check_output("busy",   bus.BUSY,   exp_busy);
        check_output("ram_we", bus.RAM_WE, exp_we);
        if (exp_ad) begin
          check_output("ram_a", bus.RAM_A, exp_a);
          check_output("ram_d", bus.RAM_D, exp_d);
        end
        check_output("rdata0", bus.RDATA0, exp_rdata[0]);
        check_output("rdata1", bus.RDATA1, exp_rdata[1]);
        if (bus.ACK0 === 1'b1) begin ack_who.push_back(0); ack_edge.push_back(edge_n); end
        if (bus.ACK1 === 1'b1) begin ack_who.push_back(1); ack_edge.push_back(edge_n); end
      end
    end
  endtask

  // Raises one requester, waits for nacks ACK pulses, then drops the request.
  // lat counts cycles with the request-raising cycle as cycle 1.
  task automatic apply_stimulus(input bit n, input bit wr, input logic [5:0] addr,
                                input logic [WIDTH-1:0] wdata, input int nacks,
                                output logic [WIDTH-1:0] rd, output int lat);
    int got = 0;
    int cyc = 1;
    rd  = '0;
    lat = -1;
    @(negedge CLK);
    if (n) begin
      bus.REQ1 = 1'b1; bus.WR1 = wr; bus.ADDR1 = addr; bus.WDATA1 = wdata;
    end else begin
      bus.REQ0 = 1'b1; bus.WR0 = wr; bus.ADDR0 = addr; bus.WDATA0 = wdata;
    end
    while (got < nacks && cyc < 300) begin
      @(posedge CLK);
      #1;
      cyc++;
      if ((n ? bus.ACK1 : bus.ACK0) === 1'b1) begin
        got++;
        if (lat < 0) lat = cyc;
        rd = n ? bus.RDATA1 : bus.RDATA0;
      end
    end
    check_output(n ? "ack1_count" : "ack0_count", got, nacks);
    @(negedge CLK);
    if (n) bus.REQ1 = 1'b0;
    else   bus.REQ0 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [WIDTH-1:0] rd, rd0, rd1;
    int lat, lat0, lat1, s, n_before;
    init_bits = {$urandom, $urandom};
    bus.REQ0 = 1'b0; bus.WR0 = 1'b0; bus.ADDR0 = '0; bus.WDATA0 = '0;
    bus.REQ1 = 1'b0; bus.WR1 = 1'b0; bus.ADDR1 = '0; bus.WDATA1 = '0;
    fork
      compare_loop();
    join_none

    // Reset values
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_output("rst_ack0",   bus.ACK0,   0);
    check_output("rst_busy",   bus.BUSY,   0);
    check_output("rst_ram_a",  bus.RAM_A,  0);
    check_output("rst_ram_we", bus.RAM_WE, 0);
    check_output("rst_rdata0", bus.RDATA0, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Word write then read back, uncontended latency
    apply_stimulus(0, 1'b1, 6'h05, 8'hA5, 1, rd, lat);
    check_output("t1_wr_latency", lat, WIDTH + 2);
    apply_stimulus(0, 1'b0, 6'h05, 8'h00, 1, rd, lat);
    check_output("t1_rd_latency", lat, WIDTH + 2);
    check_output("t1_rdata", rd, 8'hA5);

    // Address wrap 63 -> 0
    apply_stimulus(0, 1'b1, 6'h3E, 8'h3C, 1, rd, lat);
    apply_stimulus(0, 1'b0, 6'h3E, 8'h00, 1, rd, lat);
    check_output("t2_rdata", rd, 8'h3C);
    check_output("t2_ram_bits", {ram_mem[5:0], ram_mem[63:62]}, 8'h3C);

    // Simultaneous requests after reset: requester 0 first, then requester 1
    do_reset();
    fork
      apply_stimulus(0, 1'b1, 6'h08, 8'h11, 1, rd0, lat0);
      apply_stimulus(1, 1'b1, 6'h18, 8'h22, 1, rd1, lat1);
    join
    s = ack_who.size();
    check_output("t3_first",  ack_who[s-2], 0);
    check_output("t3_second", ack_who[s-1], 1);
    check_output("t3_spacing", ack_edge[s-1] - ack_edge[s-2], WIDTH + 2);

    // After requester 0 was served alone, a tie goes to requester 1
    apply_stimulus(0, 1'b0, 6'h08, 8'h00, 1, rd, lat);
    check_output("t3_rd_r0", rd, 8'h11);
    fork
      apply_stimulus(0, 1'b0, 6'h18, 8'h00, 1, rd0, lat0);
      apply_stimulus(1, 1'b0, 6'h08, 8'h00, 1, rd1, lat1);
    join
    s = ack_who.size();
    check_output("t3b_first",  ack_who[s-2], 1);
    check_output("t3b_second", ack_who[s-1], 0);
    check_output("t3b_rd0", rd0, 8'h22);
    check_output("t3b_rd1", rd1, 8'h11);

    // Requester 0 held high for two words while requester 1 waits: R0, R1, R0
    apply_stimulus(1, 1'b0, 6'h00, 8'h00, 1, rd, lat);
    fork
      apply_stimulus(0, 1'b1, 6'h28, 8'h77, 2, rd0, lat0);
      apply_stimulus(1, 1'b1, 6'h30, 8'h88, 1, rd1, lat1);
    join
    s = ack_who.size();
    check_output("t4_grant0", ack_who[s-3], 0);
    check_output("t4_grant1", ack_who[s-2], 1);
    check_output("t4_grant2", ack_who[s-1], 0);

    // Reset during bit 3 of a write: first four bits land, the rest keep their old value
    apply_stimulus(0, 1'b1, 6'h10, 8'h5A, 1, rd, lat);
    @(negedge CLK);
    bus.REQ0 = 1'b1; bus.WR0 = 1'b1; bus.ADDR0 = 6'h10; bus.WDATA0 = 8'hFF;
    n_before = ack_who.size();
    @(posedge CLK);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_output("t5_we_after_reset", bus.RAM_WE, 0);
    @(negedge CLK);
    RST = 1'b0;
    bus.REQ0 = 1'b0;
    repeat (WIDTH + 4) @(posedge CLK);
    check_output("t5_no_ack", ack_who.size(), n_before);
    apply_stimulus(0, 1'b0, 6'h10, 8'h00, 1, rd, lat);
    check_output("t5_rdata", rd, 8'h5F);

    // Inputs changed mid-transfer have no effect
    fork
      apply_stimulus(0, 1'b1, 6'h20, 8'hC3, 1, rd, lat);
      begin
        @(negedge CLK);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        bus.ADDR0  = 6'h30;
        bus.WDATA0 = 8'h00;
      end
    join
    apply_stimulus(0, 1'b0, 6'h20, 8'h00, 1, rd, lat);
    check_output("t6_rdata", rd, 8'hC3);

    // Random traffic against the reference model
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 2))
        0: apply_stimulus(0, 1'($urandom), 6'($urandom), WIDTH'($urandom), 1, rd0, lat0);
        1: apply_stimulus(1, 1'($urandom), 6'($urandom), WIDTH'($urandom), 1, rd1, lat1);
        default: fork
          apply_stimulus(0, 1'($urandom), 6'($urandom), WIDTH'($urandom), 1, rd0, lat0);
          apply_stimulus(1, 1'($urandom), 6'($urandom), WIDTH'($urandom), 1, rd1, lat1);
        join
      endcase
    end

    repeat (4) @(posedge CLK);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
